timer_bank: RTL

TIMER_BANK -- requirements
Module: timer_bank

---
 rtl/timer_bank_pkg.sv | 20 ++
 rtl/timer_bank_channel.sv | 116 +++++++++++
 rtl/timer_bank.sv | 78 +++++++
 3 files changed

// File: rtl/timer_bank_pkg.sv
// rtl/timer_bank_pkg.sv - mode encodings, one-shot states and default sizes for the timer bank
package timer_bank_pkg;

  localparam int DEFAULT_CHANNELS = 3;
  localparam int DEFAULT_WIDTH    = 24;

  typedef enum logic [1:0] {
    MODE_FREE    = 2'b00,
    MODE_RELOAD  = 2'b01,
    MODE_CAPTURE = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } os_state_e;

endpackage

// File: rtl/timer_bank_channel.sv
// rtl/timer_bank_channel.sv - one timer channel: pin synchronizer, counter, capture, flag, one-shot FSM
module timer_bank_channel
  import timer_bank_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             tr,
  input  logic             gate,
  input  logic [1:0]       mode,
  input  logic             int_pin,
  input  logic             wr,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] reload_val,
  input  logic             tf_clr,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] capture,
  output logic             tf,
  output logic             busy
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] capture_q, capture_d;
  logic             tf_q, tf_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             int_prev_q, int_prev_d;
  logic             tr_prev_q, tr_prev_d;
  os_state_e        state_q, state_d;

  mode_e mode_s;
  logic  en, run, wrap, fall, set_evt;

  assign mode_s = mode_e'(mode);
  assign en     = tr & (~gate | sync2_q) & tick;
  // One-shot channels only count while armed; other modes count whenever enabled.
  assign run    = en & ((mode_s != MODE_ONESHOT) | (state_q == ARMED));
  assign wrap   = run & (&count_q);
  assign fall   = int_prev_q & ~sync2_q;
  assign set_evt = (wrap & ~wr & (mode_s != MODE_CAPTURE))
                 | ((mode_s == MODE_CAPTURE) & fall);

  always_comb begin
    sync1_d    = int_pin;
    sync2_d    = sync1_q;
    int_prev_d = sync2_q;
    tr_prev_d  = tr;
    count_d    = count_q;
    capture_d  = capture_q;
    tf_d       = tf_q;

    if (wr) begin
      count_d = load_val;
    end else if (wrap) begin
      count_d = ((mode_s == MODE_RELOAD) || (mode_s == MODE_ONESHOT)) ? reload_val : '0;
    end else if (run) begin
      count_d = count_q + WIDTH'(1);
    end

    if ((mode_s == MODE_CAPTURE) && fall) begin
      capture_d = count_q;
    end

    // A flag-set event wins over a simultaneous software clear.
    if (tf_clr) begin
      tf_d = 1'b0;
    end
    if (set_evt) begin
      tf_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (mode_s != MODE_ONESHOT) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (tr && !tr_prev_q) state_d = ARMED;
        ARMED:   if (wrap && !wr)      state_d = DONE;
        DONE:    if (!tr)              state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      capture_q  <= '0;
      tf_q       <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      int_prev_q <= 1'b0;
      tr_prev_q  <= 1'b0;
      state_q    <= IDLE;
    end else begin
      count_q    <= count_d;
      capture_q  <= capture_d;
      tf_q       <= tf_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      int_prev_q <= int_prev_d;
      tr_prev_q  <= tr_prev_d;
      state_q    <= state_d;
    end
  end

  assign count   = count_q;
  assign capture = capture_q;
  assign tf      = tf_q;
  assign busy    = (state_q == ARMED);

endmodule

// File: rtl/timer_bank.sv
// rtl/timer_bank.sv - bank of independent timer channels; TIMER_BANK_PRESCALER_EN adds a shared tick divider
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int CHANNELS = DEFAULT_CHANNELS,
  parameter int WIDTH    = DEFAULT_WIDTH
) (
  input  logic                      timer_bank_clock_i,
  input  logic                      timer_bank_reset_i_b,
  input  logic                      timer_bank_machine_cycle_i,
`ifdef TIMER_BANK_PRESCALER_EN
  input  logic [2:0]                timer_bank_psc_i,
`endif
  input  logic [CHANNELS-1:0]       timer_bank_tr_i,
  input  logic [CHANNELS-1:0]       timer_bank_gate_i,
  input  logic [2*CHANNELS-1:0]     timer_bank_mode_i,
  input  logic [CHANNELS-1:0]       timer_bank_int_i,
  input  logic [CHANNELS-1:0]       timer_bank_wr_i,
  input  logic [WIDTH*CHANNELS-1:0] timer_bank_count_i,
  input  logic [WIDTH*CHANNELS-1:0] timer_bank_reload_i,
  input  logic [CHANNELS-1:0]       timer_bank_tf_clr_i,
  output logic [WIDTH*CHANNELS-1:0] timer_bank_count_o,
  output logic [WIDTH*CHANNELS-1:0] timer_bank_capture_o,
  output logic [CHANNELS-1:0]       timer_bank_tf_o,
  output logic [CHANNELS-1:0]       timer_bank_busy_o
);

  logic tick;

`ifdef TIMER_BANK_PRESCALER_EN
  logic [7:0] div_q, div_d;
  logic [7:0] psc_mask;

  // Pass one machine cycle out of every 2^psc: the one where the low psc bits are all ones.
  always_comb begin
    psc_mask = 8'((9'd1 << timer_bank_psc_i) - 9'd1);
    div_d    = div_q;
    if (timer_bank_machine_cycle_i) begin
      div_d = div_q + 8'd1;
    end
  end

  assign tick = timer_bank_machine_cycle_i & ((div_q & psc_mask) == psc_mask);

  always_ff @(posedge timer_bank_clock_i or negedge timer_bank_reset_i_b) begin
    if (!timer_bank_reset_i_b) begin
      div_q <= 8'd0;
    end else begin
      div_q <= div_d;
    end
  end
`else
  assign tick = timer_bank_machine_cycle_i;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    timer_bank_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk       (timer_bank_clock_i),
      .rst_n     (timer_bank_reset_i_b),
      .tick      (tick),
      .tr        (timer_bank_tr_i[g]),
      .gate      (timer_bank_gate_i[g]),
      .mode      (timer_bank_mode_i[2*g +: 2]),
      .int_pin   (timer_bank_int_i[g]),
      .wr        (timer_bank_wr_i[g]),
      .load_val  (timer_bank_count_i[WIDTH*g +: WIDTH]),
      .reload_val(timer_bank_reload_i[WIDTH*g +: WIDTH]),
      .tf_clr    (timer_bank_tf_clr_i[g]),
      .count     (timer_bank_count_o[WIDTH*g +: WIDTH]),
      .capture   (timer_bank_capture_o[WIDTH*g +: WIDTH]),
      .tf        (timer_bank_tf_o[g]),
      .busy      (timer_bank_busy_o[g])
    );
  end

endmodule
